spi_link: RTL and testbench



---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_master.sv | 68 ++++++
 rtl/spi_slave.sv | 68 ++++++
 rtl/spi_sync_edge.sv | 16 +
 rtl/spi_link.sv | 34 +++
 tb/tb_spi_link.sv | 182 ++++++++++++++++++
 6 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, register addresses and state types for the SPI link
package spi_pkg;
  localparam int SPI_DATA_W = 32;
  localparam int SPI_ADDR_W = 2;
  localparam int SPI_CNT_W  = $clog2(SPI_DATA_W) + 1;
  localparam logic [SPI_ADDR_W-1:0] SPI_TX         = 2'd0;
  localparam logic [SPI_ADDR_W-1:0] SPI_RX         = 2'd1;
  localparam logic [SPI_ADDR_W-1:0] SPI_READY      = 2'd2;
  localparam logic [SPI_ADDR_W-1:0] SPI_INTRRPT_EN = 2'd3;
  typedef enum logic [1:0] {M_IDLE, M_START, M_XFER} m_state_e;
  typedef enum logic {S_IDLE, S_XFER} s_state_e;
endpackage

// File: rtl/spi_master.sv
// spi_master: register-mapped SPI master; frames a 32-bit MSB-first transfer on the shared sclk
module spi_master
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic [SPI_ADDR_W-1:0] address,
  input  logic [SPI_DATA_W-1:0] data_in,
  input  logic                  sel,
  input  logic                  we,
  input  logic                  miso,
  output logic [SPI_DATA_W-1:0] data_out,
  output logic                  interrupt,
  output logic                  ss,
  output logic                  mosi
);
  m_state_e state;
  logic [SPI_DATA_W-1:0] tx_shift, rx_shift, rx;
  logic [SPI_CNT_W-1:0] count;
  logic en, pending, sclk_rise, sclk_fall, wr, ready, done;
  spi_sync_edge u_sclk (.clk(clk), .rst(rst), .d(sclk), .rise(sclk_rise), .fall(sclk_fall));
  assign wr = sel & we;
  assign ready = state == M_IDLE;
  assign done = state == M_XFER && sclk_fall && count == SPI_CNT_W'(SPI_DATA_W);
  assign mosi = ~ss & tx_shift[SPI_DATA_W-1];
  assign interrupt = en & pending;
  assign data_out = address == SPI_RX         ? rx :
                    address == SPI_READY      ? {{(SPI_DATA_W-1){1'b0}}, ready} :
                    address == SPI_INTRRPT_EN ? {{(SPI_DATA_W-1){1'b0}}, en} : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= M_IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      rx       <= '0;
      count    <= '0;
      ss       <= 1'b1;
      en       <= 1'b0;
      pending  <= 1'b0;
    end else begin
      if (wr && address == SPI_INTRRPT_EN) en <= data_in[0];
      pending <= (wr && (address == SPI_INTRRPT_EN || address == SPI_TX)) ? 1'b0 : pending | done;
      case (state)
        M_IDLE: if (wr && address == SPI_TX) begin
          tx_shift <= data_in;
          state    <= M_START;
        end
        M_START: if (sclk_fall) begin
          ss    <= 1'b0;
          count <= '0;
          state <= M_XFER;
        end
        M_XFER: if (sclk_rise) begin
          rx_shift <= {rx_shift[SPI_DATA_W-2:0], miso};
          count    <= count + 1'b1;
        end else if (done) begin
          ss    <= 1'b1;
          rx    <= rx_shift;
          state <= M_IDLE;
        end else if (sclk_fall && count != '0) begin
          tx_shift <= tx_shift << 1;
        end
        default: state <= M_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: register-mapped SPI slave; accepts a word only when ss frames exactly 32 bits
module spi_slave
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  ss,
  input  logic                  mosi,
  input  logic [SPI_ADDR_W-1:0] address,
  input  logic [SPI_DATA_W-1:0] data_in,
  input  logic                  sel,
  input  logic                  we,
  output logic [SPI_DATA_W-1:0] data_out,
  output logic                  interrupt,
  output logic                  miso
);
  s_state_e state;
  logic [SPI_DATA_W-1:0] tx, tx_shift, rx_shift, rx;
  logic [SPI_CNT_W-1:0] count;
  logic ready, en, pending, sclk_rise, sclk_fall, ss_rise, ss_fall, wr, done;
  spi_sync_edge u_sclk (.clk(clk), .rst(rst), .d(sclk), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge u_ss (.clk(clk), .rst(rst), .d(ss), .rise(ss_rise), .fall(ss_fall));
  assign wr = sel & we;
  assign done = state == S_XFER && ss_rise && count == SPI_CNT_W'(SPI_DATA_W);
  assign miso = tx_shift[SPI_DATA_W-1];
  assign interrupt = en & pending;
  assign data_out = address == SPI_RX         ? rx :
                    address == SPI_READY      ? {{(SPI_DATA_W-1){1'b0}}, ready} :
                    address == SPI_INTRRPT_EN ? {{(SPI_DATA_W-1){1'b0}}, en} : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx       <= '0;
      count    <= '0;
      ready    <= 1'b0;
      en       <= 1'b0;
      pending  <= 1'b0;
    end else begin
      if (wr && address == SPI_TX) tx <= data_in;
      if (wr && address == SPI_INTRRPT_EN) en <= data_in[0];
      pending <= (wr && (address == SPI_INTRRPT_EN || address == SPI_TX)) ? 1'b0 : pending | done;
      // TX register is only sampled while deselected, so writes mid-frame wait for the next one
      if (state == S_IDLE) begin
        tx_shift <= tx;
        if (ss_fall) begin
          count <= '0;
          ready <= 1'b0;
          state <= S_XFER;
        end
      end else if (ss_rise) begin
        state <= S_IDLE;
        if (done) begin
          rx    <= rx_shift;
          ready <= 1'b1;
        end
      end else if (sclk_rise) begin
        rx_shift <= {rx_shift[SPI_DATA_W-2:0], mosi};
        count    <= count + 1'b1;
      end else if (sclk_fall && count != '0) begin
        tx_shift <= tx_shift << 1;
      end
    end
  end
endmodule

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchronizer into clk with one-cycle rise/fall pulses (idle level high)
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clk) begin
    if (rst) s <= 3'b111;
    else     s <= {s[1:0], d};
  end
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/spi_link.sv
// spi_link: SPI master and slave wired back-to-back on a shared external sclk
module spi_link
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic [SPI_ADDR_W-1:0] m_address,
  input  logic [SPI_ADDR_W-1:0] s_address,
  input  logic [SPI_DATA_W-1:0] m_data_in,
  input  logic [SPI_DATA_W-1:0] s_data_in,
  input  logic                  m_sel,
  input  logic                  s_sel,
  input  logic                  m_we,
  input  logic                  s_we,
  output logic [SPI_DATA_W-1:0] m_data_out,
  output logic [SPI_DATA_W-1:0] s_data_out,
  output logic                  m_interrupt,
  output logic                  s_interrupt,
  output logic                  ss,
  output logic                  mosi,
  output logic                  miso
);
  spi_master u_master (
    .clk(clk), .rst(rst), .sclk(sclk), .address(m_address), .data_in(m_data_in),
    .sel(m_sel), .we(m_we), .miso(miso), .data_out(m_data_out),
    .interrupt(m_interrupt), .ss(ss), .mosi(mosi)
  );
  spi_slave u_slave (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .address(s_address),
    .data_in(s_data_in), .sel(s_sel), .we(s_we), .data_out(s_data_out),
    .interrupt(s_interrupt), .miso(miso)
  );
endmodule

// File: tb/tb_spi_link.sv
// tb_spi_link: randomized word-level model of the link checked against spi_link
module tb_spi_link;
  import spi_pkg::*;
  logic clk = 0, rst = 1, sclk = 1;
  logic [1:0] m_address = 0, s_address = 0;
  logic [31:0] m_data_in = 0, s_data_in = 0, m_data_out, s_data_out;
  logic m_sel = 0, s_sel = 0, m_we = 0, s_we = 0;
  logic m_interrupt, s_interrupt, ss, mosi, miso;
  int tests = 0, fails = 0;
  bit busy = 1;
  logic m_en, s_en, m_pend, s_pend, s_rdy;
  logic [31:0] m_rx, s_rx, s_txr;

  spi_link dut (
    .clk(clk), .rst(rst), .sclk(sclk),
    .m_address(m_address), .s_address(s_address),
    .m_data_in(m_data_in), .s_data_in(s_data_in),
    .m_sel(m_sel), .s_sel(s_sel), .m_we(m_we), .s_we(s_we),
    .m_data_out(m_data_out), .s_data_out(s_data_out),
    .m_interrupt(m_interrupt), .s_interrupt(s_interrupt),
    .ss(ss), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;
  always #53 sclk = ~sclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; s_en = 0; m_pend = 0; s_pend = 0; s_rdy = 0;
    m_rx = 0; s_rx = 0; s_txr = 0;
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst && !busy) begin
      chk("ss_idle", ss, 1);
      chk("mosi_idle", mosi, 0);
      chk("m_irq", m_interrupt, m_en & m_pend);
      chk("s_irq", s_interrupt, s_en & s_pend);
    end
  end

  task automatic wr(input bit side, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    if (side) begin s_address = a; s_data_in = d; s_sel = 1; s_we = 1; end
    else begin m_address = a; m_data_in = d; m_sel = 1; m_we = 1; end
    @(negedge clk);
    m_sel = 0; m_we = 0; s_sel = 0; s_we = 0;
    if (side) begin
      if (a == SPI_TX) begin s_txr = d; s_pend = 0; end
      if (a == SPI_INTRRPT_EN) begin s_en = d[0]; s_pend = 0; end
    end else begin
      if (a == SPI_TX) m_pend = 0;
      if (a == SPI_INTRRPT_EN) begin m_en = d[0]; m_pend = 0; end
    end
  endtask

  task automatic rd(input bit side, input logic [1:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    if (side) s_address = a; else m_address = a;
    #1;
    chk(name, side ? s_data_out : m_data_out, exp);
  endtask

  task automatic chk_all();
    rd(0, SPI_TX, 0, "m_tx_read");
    rd(0, SPI_RX, m_rx, "m_rx");
    rd(0, SPI_READY, 1, "m_ready");
    rd(0, SPI_INTRRPT_EN, {31'b0, m_en}, "m_en");
    rd(1, SPI_TX, 0, "s_tx_read");
    rd(1, SPI_RX, s_rx, "s_rx");
    rd(1, SPI_READY, {31'b0, s_rdy}, "s_ready");
    rd(1, SPI_INTRRPT_EN, {31'b0, s_en}, "s_en");
  endtask

  // mid: 0 none, 1 rewrite master enable, 2 rewrite slave TX, 3 master TX write while busy
  task automatic xfer(input logic [31:0] w, input int mid);
    logic [31:0] snap;
    bit ok;
    snap = s_txr;
    busy = 1;
    wr(0, SPI_TX, w);
    rd(0, SPI_READY, 0, "m_busy");
    repeat (150) @(negedge clk);
    if (mid == 1) wr(0, SPI_INTRRPT_EN, 1);
    if (mid == 2) wr(1, SPI_TX, ~snap);
    if (mid == 3) begin
      wr(0, SPI_TX, 32'hDEADBEEF);
      rd(0, SPI_READY, 0, "m_ignored");
    end
    m_address = SPI_READY;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = m_data_out[0];
    end
    chk("m_done_timeout", {31'b0, ok}, 1);
    repeat (8) @(negedge clk);
    m_rx = snap; s_rx = w; m_pend = 1; s_pend = 1; s_rdy = 1;
    busy = 0;
    chk_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 0;
    busy = 0;
    rd(0, SPI_READY, 1, "rst_m_ready");
    rd(1, SPI_READY, 0, "rst_s_ready");
    @(negedge clk); #1;
    chk("rst_ss", ss, 1);
    chk("rst_irq", {m_interrupt, s_interrupt}, 0);
    chk_all();
    xfer(32'hF0F0F0F0, 0);
    rd(1, SPI_RX, 32'hF0F0F0F0, "lit_s_rx_f0");
    rd(1, SPI_READY, 1, "lit_s_ready");
    wr(1, SPI_TX, 32'hF0F0F0F0);
    xfer(32'h0, 0);
    rd(0, SPI_RX, 32'hF0F0F0F0, "lit_m_rx_f0");
    wr(0, SPI_INTRRPT_EN, 1);
    wr(1, SPI_INTRRPT_EN, 1);
    xfer(32'hABABABAB, 0);
    @(negedge clk); #1;
    chk("lit_irqs", {m_interrupt, s_interrupt}, 2'b11);
    rd(1, SPI_RX, 32'hABABABAB, "lit_s_rx_ab");
    wr(0, SPI_INTRRPT_EN, 1);
    #1;
    chk("lit_m_irq_cleared", m_interrupt, 0);
    wr(1, SPI_TX, 32'hABABABAB);
    xfer(32'h0, 1);
    @(negedge clk); #1;
    chk("lit_m_irq_end", m_interrupt, 1);
    rd(0, SPI_RX, 32'hABABABAB, "lit_m_rx_ab");
    xfer(32'h12345678, 3);
    rd(1, SPI_RX, 32'h12345678, "lit_s_rx_ignored_busy");
    wr(1, SPI_TX, 32'h0F0F1234);
    xfer(32'h55AA00FF, 2);
    rd(0, SPI_RX, 32'h0F0F1234, "lit_m_rx_old_tx");
    xfer(32'h1, 0);
    for (int k = 0; k < 6; k++) begin
      wr(1, SPI_TX, $urandom);
      wr(0, SPI_INTRRPT_EN, {31'b0, 1'($urandom_range(0, 1))});
      wr(1, SPI_INTRRPT_EN, {31'b0, 1'($urandom_range(0, 1))});
      xfer($urandom, $urandom_range(0, 3));
    end
    wr(1, SPI_TX, 32'hCAFEF00D);
    busy = 1;
    wr(0, SPI_TX, 32'h87654321);
    repeat (150) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    chk("rst_mid_ss", ss, 1);
    busy = 0;
    rd(0, SPI_READY, 1, "rst_mid_m_ready");
    rd(1, SPI_RX, 0, "rst_mid_s_rx");
    repeat (400) @(negedge clk);
    chk_all();
    wr(1, SPI_TX, 32'h13579BDF);
    xfer(32'h2468ACE0, 0);
    rd(0, SPI_RX, 32'h13579BDF, "lit_post_rst_m_rx");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
